register_bank: RTL and testbench

- Bank of 16 general-purpose 32-bit registers for the 32-bit processor datapath.
- A 16-bit one-hot/bitmask `select` chooses which registers capture the shared data input `Din` on the clock edge.
- All 16 register contents are continuously visible on dedicated outputs q0..q15, which feed the operand multiplexers downstream.

---
 rtl/regbank_pkg.sv | 10 +
 rtl/reg_word.sv | 28 ++
 rtl/register_bank.sv | 60 ++++++
 tb/tb_register_bank.sv | 124 ++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and types for the 16 x 32-bit general-purpose register bank.
package regbank_pkg;

  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 16;

  typedef logic [WIDTH-1:0]    word_t;
  typedef logic [NUM_REGS-1:0] sel_t;

endpackage

// File: rtl/reg_word.sv
// Single WIDTH-bit storage word with load enable and async active-low clear.
module reg_word
  import regbank_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  word_t d_i,
  output word_t q_o
);

  word_t q_d, q_q;

  // Load d when enabled, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  // State register; reset clears immediately and overrides any load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_bank.sv
// 16 x 32-bit register bank: a bitmask picks which words capture the shared
// write data; every word is continuously visible on its own output port.
module register_bank
  import regbank_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  sel_t  select,
  input  word_t Din,
  output word_t q0,
  output word_t q1,
  output word_t q2,
  output word_t q3,
  output word_t q4,
  output word_t q5,
  output word_t q6,
  output word_t q7,
  output word_t q8,
  output word_t q9,
  output word_t q10,
  output word_t q11,
  output word_t q12,
  output word_t q13,
  output word_t q14,
  output word_t q15
);

  word_t q_arr [NUM_REGS];

  // One storage word per register; several select bits may be set at once,
  // in which case every selected word loads the same Din.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    reg_word u_word (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (select[i]),
      .d_i    (Din),
      .q_o    (q_arr[i])
    );
  end

  // Outputs come straight from the register state, never from Din/select.
  assign q0  = q_arr[0];
  assign q1  = q_arr[1];
  assign q2  = q_arr[2];
  assign q3  = q_arr[3];
  assign q4  = q_arr[4];
  assign q5  = q_arr[5];
  assign q6  = q_arr[6];
  assign q7  = q_arr[7];
  assign q8  = q_arr[8];
  assign q9  = q_arr[9];
  assign q10 = q_arr[10];
  assign q11 = q_arr[11];
  assign q12 = q_arr[12];
  assign q13 = q_arr[13];
  assign q14 = q_arr[14];
  assign q15 = q_arr[15];

endmodule

// File: tb/tb_register_bank.sv
// Directed testbench for register_bank.
module tb_register_bank;
  import regbank_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  sel_t  select;
  word_t Din;
  word_t q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, q10, q11, q12, q13, q14, q15;
  word_t q   [NUM_REGS];
  word_t exp_v [NUM_REGS];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_bank dut (
    .clk(clk), .rst(rst), .select(select), .Din(Din),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .q8(q8), .q9(q9), .q10(q10), .q11(q11), .q12(q12), .q13(q13), .q14(q14), .q15(q15)
  );

  assign q[0]  = q0;  assign q[1]  = q1;  assign q[2]  = q2;  assign q[3]  = q3;
  assign q[4]  = q4;  assign q[5]  = q5;  assign q[6]  = q6;  assign q[7]  = q7;
  assign q[8]  = q8;  assign q[9]  = q9;  assign q[10] = q10; assign q[11] = q11;
  assign q[12] = q12; assign q[13] = q13; assign q[14] = q14; assign q[15] = q15;

  task automatic check_all(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      checks++;
      assert (q[i] === exp_v[i]) else begin
        errors++;
        $error("FAIL %s q%0d observed=%h expected=%h", tag, i, q[i], exp_v[i]);
      end
    end
  endtask

  // Present inputs at the falling edge, let one rising edge pass, settle.
  task automatic step(input sel_t s, input word_t d);
    @(negedge clk);
    select = s;
    Din    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b0;
    select = 16'hFFFF;
    Din    = 32'hFFFF_FFFF;
    for (int i = 0; i < NUM_REGS; i++) exp_v[i] = '0;

    // Reset held with a broadcast write pending: writes ignored.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_hold");

    // Release between edges; first edge with rst high captures the broadcast.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REGS; i++) exp_v[i] = 32'hFFFF_FFFF;
    check_all("reset_release");

    // Single writes, one register per cycle.
    for (int i = 0; i < NUM_REGS; i++) begin
      step(sel_t'(1) << i, word_t'(10 + i));
      exp_v[i] = word_t'(10 + i);
      check_all($sformatf("single_%0d", i));
    end

    // Idle: no register may change.
    for (int c = 0; c < 5; c++) begin
      step(16'h0000, 32'hDEAD_BEEF);
      check_all($sformatf("hold_%0d", c));
    end

    // Two registers at once.
    step(16'h0003, 32'd13);
    exp_v[0] = 32'd13;
    exp_v[1] = 32'd13;
    check_all("multi_0003");

    // Broadcast to all.
    step(16'hFFFF, 32'h1234_5678);
    for (int i = 0; i < NUM_REGS; i++) exp_v[i] = 32'h1234_5678;
    check_all("broadcast");

    // Sparse mask.
    step(16'hA5A5, 32'hCAFE_0001);
    for (int i = 0; i < NUM_REGS; i++)
      if ((16'hA5A5 >> i) & 1) exp_v[i] = 32'hCAFE_0001;
    check_all("mask_a5a5");

    // Async reset between edges clears before the next rising edge.
    @(negedge clk);
    select = 16'hFFFF;
    Din    = 32'h5555_AAAA;
    rst    = 1'b0;
    #1;
    for (int i = 0; i < NUM_REGS; i++) exp_v[i] = '0;
    check_all("async_reset");

    // Still cleared across an edge with a write pending.
    @(posedge clk);
    #1;
    check_all("async_reset_edge");

    // Release, then a single write lands only in q15.
    @(negedge clk);
    rst    = 1'b1;
    select = 16'h0000;
    step(16'h8000, 32'd166);
    exp_v[15] = 32'd166;
    check_all("post_reset_q15");

    @(negedge clk);
    select = 16'h0000;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
